opti_result_buffer: RTL and testbench
=====================================

# opti_result_buffer

Capture-and-readout buffer sitting directly downstream of the four-section SOS IIR filter top. It records each filtered sample at the address the filter controller supplies, tracks the peak magnitude of post-settling samples, and after `filter_done` streams the whole record out over a valid/ready interface at one word per cycle. It decouples the free-running filter output from a slower consumer such as a host readout or UART bridge.

## Interface
- DEPTH_LOG2, 11, address width; buffer depth is 2^DEPTH_LOG2 words
- DATA_W, 24, sample width, signed two's complement

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cap_valid  in  1  filter output sample valid (driven by filter `data_out_valid`)
- cap_addr  in  DEPTH_LOG2  write address (filter `addr`)
- cap_data  in  DATA_W  signed sample (filter `data_out`)
- cap_stable  in  1  filter settled flag (filter `stable_out`)
- filter_done  in  1  single-cycle end-of-run pulse
- rd_start  in  1  single-cycle request to begin readout
- m_valid  out  1  readout word valid
- m_ready  in  1  consumer accepts word
- m_data  out  DATA_W  readout sample
- m_index  out  DEPTH_LOG2  buffer index of m_data
- m_last  out  1  high with the word at index 2^DEPTH_LOG2-1
- peak_abs  out  DATA_W  max |sample| over stable captures, unsigned
- sample_count  out  DEPTH_LOG2+1  accepted captures this run
- overflow  out  1  sticky: overwrite or dropped capture this run
- ready_for_read  out  1  high in state READY

## Operation
- States: CAPTURE (reset state), READY, STREAM.
- CAPTURE: each cycle with cap_valid=1 writes cap_data to mem[cap_addr], sets written[cap_addr], increments sample_count (saturates at 2^DEPTH_LOG2). If written[cap_addr] was already 1, data is overwritten and overflow is set.
- Peak: if cap_valid=1 and cap_stable=1 in CAPTURE, peak_abs <= max(peak_abs, |cap_data|); |-2^(DATA_W-1)| saturates to 2^(DATA_W-1)-1. Samples with cap_stable=0 are stored but excluded from the peak.
- CAPTURE -> READY on filter_done=1. A cap_valid in the same cycle is captured first.
- READY: cap_valid is dropped and sets overflow. rd_start=1 -> STREAM.
- STREAM: indices 0 .. 2^DEPTH_LOG2-1 are read in ascending order. Words never written read as 0. A word transfers when m_valid and m_ready are both 1. cap_valid is dropped and sets overflow; filter_done and rd_start are ignored.
- STREAM -> CAPTURE on the cycle after the m_last transfer. On that entry, written[], sample_count, peak_abs and overflow all clear. Memory contents are not cleared; the written[] mask hides them.
- rd_start outside READY and filter_done outside CAPTURE are ignored.
- Memory: single write port, synchronous read port (1-cycle latency), 2-entry output skid so that throughput is not lost under backpressure.

## Timing
- Reset (rst=1 at an edge, in any state including mid-STREAM): state=CAPTURE, m_valid=0, m_data=0, m_index=0, m_last=0, peak_abs=0, sample_count=0, overflow=0, ready_for_read=0, written[] all 0.
- Capture write, sample_count, peak_abs and overflow update at the same edge that samples cap_valid, so they are visible the next cycle.
- ready_for_read rises the cycle after filter_done.
- rd_start high in cycle n gives m_valid=1 with m_index=0 in cycle n+2.
- With m_ready held at 1, one word transfers per cycle with no bubbles: 2^DEPTH_LOG2 words in 2^DEPTH_LOG2 consecutive cycles.
- While m_valid=1 and m_ready=0, m_data, m_index and m_last hold stable; m_valid never drops without a transfer.
- After the m_last transfer, m_valid=0 in the next cycle and the block accepts captures again in that cycle.

## Test plan
- Basic run: after reset, write addr k with data k*3 for k=0..2047 with cap_stable=0, then pulse filter_done and rd_start, m_ready=1 -> 2048 words, m_data = index*3, m_last only at 2047, first m_valid 2 cycles after rd_start, sample_count=2048, peak_abs=0, overflow=0.
- Peak/saturation: stable captures of 100, -5000, -8388608, 7 -> peak_abs=8388607. A later unstable capture of 8388607 leaves the peak unchanged.
- Sparse/overwrite: write addr 5 with 0x123456, addr 5 again with 0x000011, nothing else -> readout index 5 = 0x000011, all other indices = 0, sample_count=2, overflow=1.
- Backpressure: m_ready pattern 1,0,0,1 repeating -> no word lost or duplicated, outputs stable during stalls, m_index strictly increasing.
- Illegal events: cap_valid in READY and STREAM -> overflow=1 and contents unchanged. rd_start during CAPTURE -> no m_valid. filter_done during STREAM -> no effect.
- Reset mid-stream at index 700 -> next cycle m_valid=0, state CAPTURE, counters zero. A new capture and readout then produce the new data only, with unwritten indices reading 0.

Source files
------------

// File: rtl/opti_result_buffer_if.sv
// Capture, readout-stream and status signals of the result buffer, grouped as one bundle.
// The slave side is the buffer itself; the master side is the filter plus the readout consumer.
interface opti_result_buffer_if #(
  parameter int DEPTH_LOG2 = 11,
  parameter int DATA_W     = 24
);
  logic                  cap_valid;
  logic [DEPTH_LOG2-1:0] cap_addr;
  logic [DATA_W-1:0]     cap_data;
  logic                  cap_stable;
  logic                  filter_done;
  logic                  rd_start;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_W-1:0]     m_data;
  logic [DEPTH_LOG2-1:0] m_index;
  logic                  m_last;
  logic [DATA_W-1:0]     peak_abs;
  logic [DEPTH_LOG2:0]   sample_count;
  logic                  overflow;
  logic                  ready_for_read;

  modport slave (
    input  cap_valid, cap_addr, cap_data, cap_stable, filter_done, rd_start, m_ready,
    output m_valid, m_data, m_index, m_last, peak_abs, sample_count, overflow, ready_for_read
  );

  modport master (
    output cap_valid, cap_addr, cap_data, cap_stable, filter_done, rd_start, m_ready,
    input  m_valid, m_data, m_index, m_last, peak_abs, sample_count, overflow, ready_for_read
  );
endinterface

// File: rtl/opti_result_buffer.sv
// Records filter output samples by address and tracks the settled peak magnitude.
// After the run ends, streams the whole record out through a 2-entry skid FIFO.
module opti_result_buffer #(
  parameter int DEPTH_LOG2 = 11,
  parameter int DATA_W     = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  opti_result_buffer_if.slave    bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   COUNT_MAX  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] LAST_INDEX = {DEPTH_LOG2{1'b1}};
  localparam logic [DATA_W-1:0]     MOST_NEG   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]     MOST_POS   = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {CAPTURE, READY, STREAM} state_t;

  state_t                state_reg;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0]      written_reg;
  logic [DEPTH_LOG2:0]   sample_count_reg;
  logic [DATA_W-1:0]     peak_reg;
  logic                  overflow_reg;
  logic                  ready_reg;

  // Read issue pointer; the extra MSB marks that every index has been issued.
  logic [DEPTH_LOG2:0]   rd_ptr_reg;
  logic                  rd_valid_reg;
  logic                  rd_written_reg;
  logic [DATA_W-1:0]     rd_data_reg;
  logic [DEPTH_LOG2-1:0] rd_index_reg;

  logic [DATA_W-1:0]     fifo_data_reg  [2];
  logic [DEPTH_LOG2-1:0] fifo_index_reg [2];
  logic                  fifo_head_reg;
  logic                  fifo_tail_reg;
  logic [1:0]            fifo_count_reg;

  logic                  capture_we;
  logic [DATA_W-1:0]     cap_neg;
  logic [DATA_W-1:0]     cap_abs;
  logic [DATA_W-1:0]     rd_word;
  logic                  out_from_fifo;
  logic                  out_valid;
  logic [DATA_W-1:0]     out_data;
  logic [DEPTH_LOG2-1:0] out_index;
  logic                  out_last;
  logic                  push;
  logic                  fifo_pop;
  logic [1:0]            held;
  logic                  issue;
  logic                  stream_end;

  assign capture_we = (state_reg == CAPTURE) && bus.cap_valid;
  assign cap_neg    = '0 - bus.cap_data;

  always_comb begin
    cap_abs = bus.cap_data;
    if (bus.cap_data == MOST_NEG) begin
      cap_abs = MOST_POS;
    end else if (bus.cap_data[DATA_W-1]) begin
      cap_abs = cap_neg;
    end
  end

  // Unwritten entries are masked to zero instead of clearing the RAM.
  assign rd_word       = rd_written_reg ? rd_data_reg : '0;
  assign out_from_fifo = (fifo_count_reg != 2'd0);
  assign out_valid     = out_from_fifo || rd_valid_reg;

  always_comb begin
    out_data  = '0;
    out_index = '0;
    if (out_from_fifo) begin
      out_data  = fifo_data_reg[fifo_head_reg];
      out_index = fifo_index_reg[fifo_head_reg];
    end else if (rd_valid_reg) begin
      out_data  = rd_word;
      out_index = rd_index_reg;
    end
  end

  assign out_last   = out_valid && (out_index == LAST_INDEX);
  // A fresh RAM word bypasses the FIFO only when it is consumed immediately.
  assign push       = rd_valid_reg && (out_from_fifo || !bus.m_ready);
  assign fifo_pop   = out_from_fifo && bus.m_ready;
  assign held       = fifo_count_reg + {1'b0, rd_valid_reg};
  // Issue only when a slot is guaranteed, so m_ready never gates the RAM read.
  assign issue      = (state_reg == STREAM) && !rd_ptr_reg[DEPTH_LOG2] && (held < 2'd2);
  assign stream_end = (state_reg == STREAM) && out_last && bus.m_ready;

  assign bus.m_valid        = out_valid;
  assign bus.m_data         = out_data;
  assign bus.m_index        = out_index;
  assign bus.m_last         = out_last;
  assign bus.peak_abs       = peak_reg;
  assign bus.sample_count   = sample_count_reg;
  assign bus.overflow       = overflow_reg;
  assign bus.ready_for_read = ready_reg;

  always_ff @(posedge clk) begin
    if (capture_we && !rst) begin
      mem[bus.cap_addr] <= bus.cap_data;
    end
    if (issue) begin
      rd_data_reg <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_reg[fifo_tail_reg]  <= rd_word;
      fifo_index_reg[fifo_tail_reg] <= rd_index_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stream_end) begin
      written_reg <= '0;
    end else if (capture_we) begin
      written_reg[bus.cap_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= CAPTURE;
      sample_count_reg <= '0;
      peak_reg         <= '0;
      overflow_reg     <= 1'b0;
      ready_reg        <= 1'b0;
      rd_ptr_reg       <= '0;
      rd_valid_reg     <= 1'b0;
      rd_written_reg   <= 1'b0;
      rd_index_reg     <= '0;
      fifo_head_reg    <= 1'b0;
      fifo_tail_reg    <= 1'b0;
      fifo_count_reg   <= 2'd0;
    end else begin
      rd_valid_reg <= issue;
      if (issue) begin
        rd_written_reg <= written_reg[rd_ptr_reg[DEPTH_LOG2-1:0]];
        rd_index_reg   <= rd_ptr_reg[DEPTH_LOG2-1:0];
        rd_ptr_reg     <= rd_ptr_reg + COUNT_ONE;
      end
      if (push) begin
        fifo_tail_reg <= ~fifo_tail_reg;
      end
      if (fifo_pop) begin
        fifo_head_reg <= ~fifo_head_reg;
      end
      fifo_count_reg <= fifo_count_reg + {1'b0, push} - {1'b0, fifo_pop};

      case (state_reg)
        CAPTURE: begin
          if (bus.cap_valid) begin
            if (sample_count_reg != COUNT_MAX) begin
              sample_count_reg <= sample_count_reg + COUNT_ONE;
            end
            if (written_reg[bus.cap_addr]) begin
              overflow_reg <= 1'b1;
            end
            if (bus.cap_stable && (cap_abs > peak_reg)) begin
              peak_reg <= cap_abs;
            end
          end
          if (bus.filter_done) begin
            state_reg <= READY;
            ready_reg <= 1'b1;
          end
        end
        READY: begin
          if (bus.cap_valid) begin
            overflow_reg <= 1'b1;
          end
          if (bus.rd_start) begin
            state_reg  <= STREAM;
            ready_reg  <= 1'b0;
            rd_ptr_reg <= '0;
          end
        end
        STREAM: begin
          if (bus.cap_valid) begin
            overflow_reg <= 1'b1;
          end
          if (stream_end) begin
            state_reg        <= CAPTURE;
            sample_count_reg <= '0;
            peak_reg         <= '0;
            overflow_reg     <= 1'b0;
          end
        end
        default: begin
          state_reg <= CAPTURE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_opti_result_buffer.sv
// Scoreboard bench for opti_result_buffer: expected words are queued when a readout
// is requested and popped as the DUT transfers them.
module tb_opti_result_buffer;
  localparam int DL    = 11;
  localparam int DW    = 24;
  localparam int DEPTH = 1 << DL;

  logic clk = 1'b0;
  logic rst = 1'b1;

  opti_result_buffer_if #(.DEPTH_LOG2(DL), .DATA_W(DW)) bus ();

  opti_result_buffer #(.DEPTH_LOG2(DL), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int index;
    int data;
  } word_t;

  word_t          exp_q[$];
  int             check_count = 0;
  int             error_count = 0;
  int             exp_data[DEPTH];
  bit             exp_written[DEPTH];
  int             exp_count = 0;
  bit             exp_ovf = 1'b0;
  bit             stall_prev = 1'b0;
  logic [DW-1:0]  held_data;
  logic [DL-1:0]  held_index;
  logic           held_last;

  task automatic check(input string tag, input longint got, input longint exp);
    check_count++;
    if (got != exp) begin
      error_count++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_word(input int i);
    return exp_written[i] ? exp_data[i] : 0;
  endfunction

  task automatic clear_model;
    for (int i = 0; i < DEPTH; i++) exp_written[i] = 1'b0;
    exp_count = 0;
    exp_ovf   = 1'b0;
  endtask

  task automatic capture(input int addr, input int data, input bit stable);
    bus.cap_valid  = 1'b1;
    bus.cap_addr   = addr[DL-1:0];
    bus.cap_data   = data[DW-1:0];
    bus.cap_stable = stable;
    if (exp_written[addr]) exp_ovf = 1'b1;
    exp_written[addr] = 1'b1;
    exp_data[addr]    = data & 32'h00FF_FFFF;
    if (exp_count < DEPTH) exp_count++;
    tick;
    bus.cap_valid = 1'b0;
  endtask

  task automatic pulse_done;
    check("ready_before_done", bus.ready_for_read, 0);
    bus.filter_done = 1'b1;
    tick;
    bus.filter_done = 1'b0;
    check("ready_after_done", bus.ready_for_read, 1);
  endtask

  task automatic check_status(input string name);
    check({name, "_count"}, bus.sample_count, exp_count);
    check({name, "_ovf"}, bus.overflow, exp_ovf);
  endtask

  // Streams the record; optional 1,0,0,1 backpressure, illegal events, or a reset at stop_at.
  task automatic readout(input string name, input bit backpressure, input bit inject, input int stop_at);
    int cyc;
    bit stopped;
    for (int i = 0; i < DEPTH; i++) begin
      word_t w;
      w.index = i;
      w.data  = exp_word(i);
      exp_q.push_back(w);
    end
    bus.m_ready  = 1'b0;
    bus.rd_start = 1'b1;
    tick;
    bus.rd_start = 1'b0;
    check("first_valid_early", bus.m_valid, 0);
    tick;
    check("first_valid", bus.m_valid, 1);
    check("first_index", bus.m_index, 0);
    cyc = 0;
    stopped = 1'b0;
    while (exp_q.size() > 0 && cyc < 4 * DEPTH && !stopped) begin
      if (stop_at >= 0 && bus.m_valid && int'(bus.m_index) == stop_at) begin
        rst = 1'b1;
        bus.m_ready = 1'b0;
        tick;
        rst = 1'b0;
        exp_q.delete();
        clear_model();
        stopped = 1'b1;
      end else begin
        bus.m_ready     = backpressure ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        bus.cap_valid   = inject && (cyc == 10);
        bus.cap_addr    = 11'd3;
        bus.cap_data    = 24'h000777;
        bus.cap_stable  = 1'b1;
        bus.filter_done = inject && (cyc == 20);
        if (inject && cyc == 12) check("ovf_in_stream", bus.overflow, 1);
        tick;
        cyc++;
      end
    end
    bus.m_ready     = 1'b0;
    bus.cap_valid   = 1'b0;
    bus.filter_done = 1'b0;
    check("readout_drain", exp_q.size(), 0);
    if (!backpressure && !stopped) check("no_bubbles", cyc, DEPTH);
    check("end_valid", bus.m_valid, 0);
    check("end_ready", bus.ready_for_read, 0);
    check("end_count", bus.sample_count, 0);
    check("end_ovf", bus.overflow, 0);
    check("end_peak", bus.peak_abs, 0);
    if (!stopped) clear_model();
    $display("txn readout %s cycles=%0d stopped=%0d checks=%0d errors=%0d",
             name, cyc, stopped, check_count, error_count);
  endtask

  always @(negedge clk) begin
    word_t w;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", bus.m_valid, 1);
        check("stall_data", bus.m_data, held_data);
        check("stall_index", bus.m_index, held_index);
        check("stall_last", bus.m_last, held_last);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", bus.m_index, DEPTH);
        end else begin
          w = exp_q.pop_front();
          check("word_index", bus.m_index, w.index);
          check("word_data", bus.m_data, w.data);
          check("word_last", bus.m_last, w.index == DEPTH - 1);
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      held_data  = bus.m_data;
      held_index = bus.m_index;
      held_last  = bus.m_last;
    end
  end

  initial begin
    bit seen;
    bus.cap_valid   = 1'b0;
    bus.cap_addr    = '0;
    bus.cap_data    = '0;
    bus.cap_stable  = 1'b0;
    bus.filter_done = 1'b0;
    bus.rd_start    = 1'b0;
    bus.m_ready     = 1'b0;
    clear_model();
    tick;
    tick;
    rst = 1'b0;
    check("rst_valid", bus.m_valid, 0);
    check("rst_data", bus.m_data, 0);
    check("rst_index", bus.m_index, 0);
    check("rst_last", bus.m_last, 0);
    check("rst_peak", bus.peak_abs, 0);
    check("rst_count", bus.sample_count, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_ready", bus.ready_for_read, 0);
    $display("txn reset checks=%0d errors=%0d", check_count, error_count);

    for (int k = 0; k < DEPTH; k++) capture(k, k * 3, 1'b0);
    check_status("basic");
    check("basic_peak", bus.peak_abs, 0);
    pulse_done();
    readout("basic", 1'b0, 1'b0, -1);

    bus.rd_start = 1'b1;
    tick;
    bus.rd_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      seen |= bus.m_valid;
    end
    check("rdstart_in_capture", seen, 0);
    check("rdstart_ready", bus.ready_for_read, 0);

    capture(9, 500000, 1'b0);
    check("peak_unstable_first", bus.peak_abs, 0);
    capture(10, 100, 1'b1);
    check("peak_100", bus.peak_abs, 100);
    capture(11, -5000, 1'b1);
    check("peak_5000", bus.peak_abs, 5000);
    capture(12, -8388608, 1'b1);
    check("peak_sat", bus.peak_abs, 24'h7FFFFF);
    capture(13, 7, 1'b1);
    check("peak_hold", bus.peak_abs, 24'h7FFFFF);
    capture(14, 8388607, 1'b0);
    check("peak_unstable_last", bus.peak_abs, 24'h7FFFFF);
    check_status("peak");
    pulse_done();
    bus.cap_valid = 1'b1;
    bus.cap_addr  = 11'd11;
    bus.cap_data  = 24'h000999;
    tick;
    bus.cap_valid = 1'b0;
    check("ovf_in_ready", bus.overflow, 1);
    check("ready_after_illegal", bus.ready_for_read, 1);
    $display("txn peak checks=%0d errors=%0d", check_count, error_count);
    readout("peak_illegal", 1'b0, 1'b1, -1);

    capture(5, 32'h123456, 1'b0);
    capture(5, 32'h000011, 1'b0);
    check_status("sparse");
    pulse_done();
    readout("sparse_backpressure", 1'b1, 1'b0, -1);

    for (int k = 0; k < 1024; k++) capture(k, k + 1, 1'b1);
    pulse_done();
    readout("midstream_reset", 1'b0, 1'b0, 700);

    capture(2, 32'h000055, 1'b0);
    capture(2000, 32'hAAAAAA, 1'b1);
    check_status("after_reset");
    check("after_reset_peak", bus.peak_abs, 24'h555556);
    pulse_done();
    readout("after_reset", 1'b1, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end
endmodule
